// File: rtl/multiply_issue_scheduler.sv
// Round-robin, credit-gated issue of two requesters into one shared multiply pipeline,
// with in-flight tracking and per-requester response FIFOs. Optional perf counters: MULT_SCHED_PERF_EN.

module multiply_issue_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 41
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [DW-1:0]          head
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW:0]   wr_ptr_r;
  logic [PW:0]   rd_ptr_r;
  logic          wr_en_s;
  logic          rd_en_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign occupancy = wr_ptr_r - rd_ptr_r;
  assign head      = mem_r[rd_ptr_r[PW-1:0]];
  assign rd_en_s   = pop & ~empty;
  // a full FIFO still takes a push when its head leaves in the same cycle
  assign wr_en_s   = push & (~full | rd_en_s);

  // read/write pointers with wrap bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
    end
  end

  // storage array
  always_ff @(posedge clock) begin
    if (wr_en_s) mem_r[wr_ptr_r[PW-1:0]] <= push_data;
  end
endmodule

module multiply_issue_scheduler #(
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [7:0]  req0_tag,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [7:0]  req1_tag,
  output logic        mul_idle,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [7:0]  mul_tag,
  input  logic        res_idle,
  input  logic [32:0] res_z,
  input  logic [7:0]  res_tag,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [32:0] rsp0_z,
  output logic [7:0]  rsp0_tag,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [32:0] rsp1_z,
  output logic [7:0]  rsp1_tag,
  output logic        err
`ifdef MULT_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [15:0] perf_stall0,
  output logic [15:0] perf_stall1
`endif
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DRW = $clog2(LAT + 1);

  logic               mul_idle_r;
  logic [31:0]        mul_a_r;
  logic [31:0]        mul_b_r;
  logic [7:0]         mul_tag_r;
  logic               mul_id_r;
  logic               rr_last_r;
  logic               err_r;
  logic [DRW-1:0]     drain_cnt_r;
  logic [LAT-1:0]     rec_valid_r;
  logic [LAT-1:0]     rec_id_r;
  logic [7:0]         rec_tag_r [LAT];

  logic               drain_done_s;
  logic [1:0]         valid_s;
  logic [1:0]         elig_s;
  logic [1:0]         grant_s;
  logic [1:0][CW-1:0] infl_s;
  logic [1:0][CW-1:0] occ_s;
  logic [1:0][CW-1:0] cnt_s;
  logic [1:0]         push_s;
  logic [1:0]         pop_s;
  logic [1:0]         full_s;
  logic [1:0]         empty_s;
  logic [1:0]         ovf_s;
  logic               mis_s;
  logic [40:0]        head0_s;
  logic [40:0]        head1_s;

  assign drain_done_s = (drain_cnt_r == {DRW{1'b0}});
  assign valid_s      = {req1_valid, req0_valid};
  assign pop_s        = {rsp1_valid & rsp1_ready, rsp0_valid & rsp0_ready};
  assign ovf_s        = push_s & full_s & ~pop_s;

  // stale pipeline results are ignored for LAT cycles after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_cnt_r <= DRW'(LAT);
    end else if (!drain_done_s) begin
      drain_cnt_r <= drain_cnt_r - {{(DRW-1){1'b0}}, 1'b1};
    end
  end

  // credits: FIFO occupancy plus ops in the issue register and the in-flight record
  always_comb begin
    infl_s = '0;
    cnt_s  = '0;
    elig_s = 2'b00;
    for (int n = 0; n < 2; n++) begin
      infl_s[n] = CW'(!mul_idle_r && (mul_id_r == 1'(n)));
      for (int k = 0; k < LAT; k++) begin
        infl_s[n] = infl_s[n] + CW'(rec_valid_r[k] && (rec_id_r[k] == 1'(n)));
      end
      cnt_s[n]  = occ_s[n] + infl_s[n];
      elig_s[n] = valid_s[n] & (cnt_s[n] < CW'(FIFO_DEPTH)) & drain_done_s;
    end
  end

  // round-robin arbitration; rr_last_r names the requester granted most recently
  always_comb begin
    grant_s = 2'b00;
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = rr_last_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  // issue register feeding the pipeline
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_idle_r <= 1'b1;
      mul_a_r    <= 32'h0000_0000;
      mul_b_r    <= 32'h0000_0000;
      mul_tag_r  <= 8'h00;
      mul_id_r   <= 1'b0;
      rr_last_r  <= 1'b1;
    end else if (grant_s[0]) begin
      mul_idle_r <= 1'b0;
      mul_a_r    <= req0_a;
      mul_b_r    <= req0_b;
      mul_tag_r  <= req0_tag;
      mul_id_r   <= 1'b0;
      rr_last_r  <= 1'b0;
    end else if (grant_s[1]) begin
      mul_idle_r <= 1'b0;
      mul_a_r    <= req1_a;
      mul_b_r    <= req1_b;
      mul_tag_r  <= req1_tag;
      mul_id_r   <= 1'b1;
      rr_last_r  <= 1'b1;
    end else begin
      mul_idle_r <= 1'b1;
    end
  end

  assign mul_idle = mul_idle_r;
  assign mul_a    = mul_a_r;
  assign mul_b    = mul_b_r;
  assign mul_tag  = mul_tag_r;

  // in-flight record; its tail lines up with the result leaving the pipeline
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rec_valid_r <= {LAT{1'b0}};
      rec_id_r    <= {LAT{1'b0}};
      for (int k = 0; k < LAT; k++) rec_tag_r[k] <= 8'h00;
    end else begin
      rec_valid_r[0] <= ~mul_idle_r;
      rec_id_r[0]    <= mul_id_r;
      rec_tag_r[0]   <= mul_tag_r;
      for (int k = 1; k < LAT; k++) begin
        rec_valid_r[k] <= rec_valid_r[k-1];
        rec_id_r[k]    <= rec_id_r[k-1];
        rec_tag_r[k]   <= rec_tag_r[k-1];
      end
    end
  end

  // result routing and consistency check
  always_comb begin
    push_s = 2'b00;
    mis_s  = 1'b0;
    if (drain_done_s) begin
      if (rec_valid_r[LAT-1]) begin
        push_s[rec_id_r[LAT-1]] = 1'b1;
        mis_s = res_idle | (res_tag != rec_tag_r[LAT-1]);
      end else begin
        mis_s = ~res_idle;
      end
    end else begin
      push_s = 2'b00;
    end
  end

  // sticky error flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (mis_s || (|ovf_s)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;

  multiply_issue_resp_fifo #(.DEPTH(FIFO_DEPTH), .DW(41)) u_fifo0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_s[0]),
    .push_data ({res_z, res_tag}),
    .pop       (pop_s[0]),
    .empty     (empty_s[0]),
    .full      (full_s[0]),
    .occupancy (occ_s[0]),
    .head      (head0_s)
  );

  multiply_issue_resp_fifo #(.DEPTH(FIFO_DEPTH), .DW(41)) u_fifo1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_s[1]),
    .push_data ({res_z, res_tag}),
    .pop       (pop_s[1]),
    .empty     (empty_s[1]),
    .full      (full_s[1]),
    .occupancy (occ_s[1]),
    .head      (head1_s)
  );

  assign rsp0_valid = ~empty_s[0];
  assign rsp0_z     = head0_s[40:8];
  assign rsp0_tag   = head0_s[7:0];
  assign rsp1_valid = ~empty_s[1];
  assign rsp1_z     = head1_s[40:8];
  assign rsp1_tag   = head1_s[7:0];

`ifdef MULT_SCHED_PERF_EN
  logic [31:0] perf_issue_r;
  logic [15:0] perf_stall0_r;
  logic [15:0] perf_stall1_r;

  // saturating event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_r  <= 32'h0000_0000;
      perf_stall0_r <= 16'h0000;
      perf_stall1_r <= 16'h0000;
    end else begin
      if ((|grant_s) && (perf_issue_r != {32{1'b1}})) perf_issue_r <= perf_issue_r + 32'd1;
      if (req0_valid && !req0_ready && (perf_stall0_r != {16{1'b1}})) perf_stall0_r <= perf_stall0_r + 16'd1;
      if (req1_valid && !req1_ready && (perf_stall1_r != {16{1'b1}})) perf_stall1_r <= perf_stall1_r + 16'd1;
    end
  end

  assign perf_issue  = perf_issue_r;
  assign perf_stall0 = perf_stall0_r;
  assign perf_stall1 = perf_stall1_r;
`endif
endmodule

// File: tb/tb_multiply_issue_scheduler.sv
// Directed bench for multiply_issue_scheduler; the pipeline stand-in returns z = {0, a ^ b}
// after LAT clocks and is never reset.

module tb_multiply_issue_scheduler;
  localparam int LAT        = 3;
  localparam int FIFO_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0]  req0_tag, req1_tag;
  logic        mul_idle;
  logic [31:0] mul_a, mul_b;
  logic [7:0]  mul_tag;
  logic        res_idle;
  logic [32:0] res_z;
  logic [7:0]  res_tag;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [32:0] rsp0_z, rsp1_z;
  logic [7:0]  rsp0_tag, rsp1_tag;
  logic        err;
`ifdef MULT_SCHED_PERF_EN
  logic [31:0] perf_issue;
  logic [15:0] perf_stall0, perf_stall1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]     inj_xor = 8'h00;
  logic [LAT-1:0] p_idle  = {LAT{1'b1}};
  logic [31:0]    p_z   [LAT];
  logic [7:0]     p_tag [LAT];
  logic [71:0]    q0 [$];
  logic [71:0]    q1 [$];

  multiply_issue_scheduler #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .mul_idle(mul_idle), .mul_a(mul_a), .mul_b(mul_b), .mul_tag(mul_tag),
    .res_idle(res_idle), .res_z(res_z), .res_tag(res_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_tag(rsp1_tag),
    .err(err)
`ifdef MULT_SCHED_PERF_EN
    , .perf_issue(perf_issue), .perf_stall0(perf_stall0), .perf_stall1(perf_stall1)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    p_idle   <= {p_idle[LAT-2:0], mul_idle};
    p_z[0]   <= mul_a ^ mul_b;
    p_tag[0] <= mul_tag;
    for (int k = 1; k < LAT; k++) begin
      p_z[k]   <= p_z[k-1];
      p_tag[k] <= p_tag[k-1];
    end
  end

  assign res_idle = p_idle[LAT-1];
  assign res_z    = {1'b0, p_z[LAT-1]};
  assign res_tag  = p_tag[LAT-1] ^ inj_xor;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // samples handshakes just after the inputs settle, then advances to the next falling edge
  task automatic tick();
    logic [71:0] e;
    #1;
    if (req0_valid && req0_ready) q0.push_back({req0_a, req0_b, req0_tag});
    if (req1_valid && req1_ready) q1.push_back({req1_a, req1_b, req1_tag});
    if (rsp0_valid && rsp0_ready) begin
      check_eq("rsp0_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check_eq("rsp0_tag", 64'(rsp0_tag), 64'(e[7:0]));
        check_eq("rsp0_z", 64'(rsp0_z), 64'({1'b0, e[71:40] ^ e[39:8]}));
      end
    end
    if (rsp1_valid && rsp1_ready) begin
      check_eq("rsp1_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check_eq("rsp1_tag", 64'(rsp1_tag), 64'(e[7:0]));
        check_eq("rsp1_z", 64'(rsp1_z), 64'({1'b0, e[71:40] ^ e[39:8]}));
      end
    end
    @(negedge clock);
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [7:0] tag);
    req0_valid = v; req0_a = a; req0_b = 32'h4000_0000; req0_tag = tag;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [7:0] tag);
    req1_valid = v; req1_a = a; req1_b = 32'h4000_0000; req1_tag = tag;
  endtask

  initial begin
    int  n0, n1;
    logic g0, g1;
    reset_n = 1'b0;
    set_req0(1'b1, 32'h0, 8'h00);
    set_req1(1'b1, 32'h0, 8'h00);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_mul_idle", 64'(mul_idle), 64'd1);
    check_eq("rst_mul_a", 64'(mul_a), 64'd0);
    check_eq("rst_mul_tag", 64'(mul_tag), 64'd0);
    check_eq("rst_req0_ready", 64'(req0_ready), 64'd0);
    check_eq("rst_req1_ready", 64'(req1_ready), 64'd0);
    check_eq("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check_eq("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_n = 1'b1;
    repeat (4) tick();

    // both requesters every cycle: grants alternate starting with req0
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      set_req0(1'b1, {8'h3F, 16'h0, 8'hA0 + 8'(n0)}, 8'hA0 + 8'(n0));
      set_req1(1'b1, {8'h3F, 16'h0, 8'hB0 + 8'(n1)}, 8'hB0 + 8'(n1));
      #1;
      check_eq("t2_grant0", 64'(req0_ready), 64'((i % 2) == 0));
      check_eq("t2_grant1", 64'(req1_ready), 64'((i % 2) == 1));
      g0 = req0_ready; g1 = req1_ready;
      tick();
      n0 += int'(g0); n1 += int'(g1);
      check_eq("t2_mul_busy", 64'(mul_idle), 64'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) tick();
    check_eq("t2_count0", 64'(n0), 64'd3);
    check_eq("t2_count1", 64'(n1), 64'd3);
    check_eq("t2_drained0", 64'(q0.size()), 64'd0);
    check_eq("t2_drained1", 64'(q1.size()), 64'd0);

    // single req0 op, latency
    rsp0_ready = 1'b0;
    set_req0(1'b1, 32'h3F80_0000, 8'h11);
    #1;
    check_eq("t1_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    check_eq("t1_mul_idle", 64'(mul_idle), 64'd0);
    check_eq("t1_mul_a", 64'(mul_a), 64'h3F80_0000);
    check_eq("t1_mul_b", 64'(mul_b), 64'h4000_0000);
    check_eq("t1_mul_tag", 64'(mul_tag), 64'h11);
    tick();
    check_eq("t1_bubble", 64'(mul_idle), 64'd1);
    check_eq("t1_mul_a_hold", 64'(mul_a), 64'h3F80_0000);
    tick();
    tick();
    check_eq("t1_rsp_early", 64'(rsp0_valid), 64'd0);
    tick();
    check_eq("t1_rsp_valid", 64'(rsp0_valid), 64'd1);
    check_eq("t1_rsp_z", 64'(rsp0_z), 64'h0_7F80_0000);
    check_eq("t1_rsp_tag", 64'(rsp0_tag), 64'h11);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    check_eq("t1_rsp_popped", 64'(rsp0_valid), 64'd0);

    // stalled rsp0: exactly FIFO_DEPTH accepts, req1 unaffected
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      set_req0(1'b1, {8'h3F, 16'h0, 8'hC0 + 8'(n0)}, 8'hC0 + 8'(n0));
      #1;
      check_eq("t3_ready0", 64'(req0_ready), 64'(i < FIFO_DEPTH));
      g0 = req0_ready;
      tick();
      n0 += int'(g0);
    end
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req1(1'b1, {8'h3F, 16'h0, 8'hD0 + 8'(i)}, 8'hD0 + 8'(i));
      #1;
      check_eq("t3_blocked0", 64'(req0_ready), 64'd0);
      check_eq("t3_ready1", 64'(req1_ready), 64'd1);
      tick();
      check_eq("t3_mul_busy", 64'(mul_idle), 64'd0);
    end
    req1_valid = 1'b0;
    tick();

    // FIFO0 full: pop while new results keep arriving; order preserved through the scoreboard
    check_eq("t4_full_valid", 64'(rsp0_valid), 64'd1);
    check_eq("t4_head_tag", 64'(rsp0_tag), 64'hC0);
    rsp0_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req0(1'b1, {8'h3F, 16'h0, 8'hC0 + 8'(n0)}, 8'hC0 + 8'(n0));
      #1;
      g0 = req0_ready;
      tick();
      n0 += int'(g0);
    end
    req0_valid = 1'b0;
    repeat (10) tick();
    check_eq("t4_drained0", 64'(q0.size()), 64'd0);
    check_eq("t4_drained1", 64'(q1.size()), 64'd0);
    check_eq("t4_err", 64'(err), 64'd0);

    // corrupted returned tag
    rsp0_ready = 1'b0;
    inj_xor = 8'h01;
    set_req0(1'b1, {8'h3F, 16'h0, 8'h55}, 8'h55);
    tick();
    req0_valid = 1'b0;
    repeat (5) tick();
    check_eq("t5_err", 64'(err), 64'd1);
    check_eq("t5_pushed", 64'(rsp0_valid), 64'd1);
    check_eq("t5_tag", 64'(rsp0_tag), 64'h54);
    inj_xor = 8'h00;
    repeat (3) tick();
    check_eq("t5_err_sticky", 64'(err), 64'd1);

    // reset with ops in flight; stale results must be dropped during the drain
    for (int i = 0; i < 3; i++) begin
      set_req0(1'b1, {8'h3F, 16'h0, 8'h61 + 8'(i)}, 8'h61 + 8'(i));
      #1;
      check_eq("t6_issue", 64'(req0_ready), 64'd1);
      tick();
    end
    req0_valid = 1'b0;
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    tick();
    tick();
    check_eq("t6_rst_err", 64'(err), 64'd0);
    check_eq("t6_rst_rsp0", 64'(rsp0_valid), 64'd0);
    check_eq("t6_rst_idle", 64'(mul_idle), 64'd1);
    reset_n = 1'b1;
    set_req0(1'b1, {8'h3F, 16'h0, 8'h71}, 8'h71);
    set_req1(1'b1, {8'h3F, 16'h0, 8'h81}, 8'h81);
    for (int i = 0; i < LAT; i++) begin
      #1;
      check_eq("t6_drain_ready0", 64'(req0_ready), 64'd0);
      check_eq("t6_drain_ready1", 64'(req1_ready), 64'd0);
      check_eq("t6_drain_err", 64'(err), 64'd0);
      check_eq("t6_drain_rsp0", 64'(rsp0_valid), 64'd0);
      check_eq("t6_drain_rsp1", 64'(rsp1_valid), 64'd0);
      tick();
    end
    #1;
    check_eq("t6_first_grant0", 64'(req0_ready), 64'd1);
    check_eq("t6_first_grant1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    check_eq("t6_second_grant1", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (8) tick();
    check_eq("t6_drained0", 64'(q0.size()), 64'd0);
    check_eq("t6_drained1", 64'(q1.size()), 64'd0);
    check_eq("t6_err", 64'(err), 64'd0);
    check_eq("t6_rsp0_empty", 64'(rsp0_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
